// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, one-shot imem request/response handshake,
// latched instruction, retire counter and sticky illegal-target trap.
//   state | meaning
//   FETCH | imem_req high for one cycle at imem_addr = pc
//   WAIT  | waiting for imem_rvalid, latch imem_rdata on arrival
//   HOLD  | instr valid for pc, waiting for an unstalled advance
//   ERR   | illegal next-PC taken, fetching stopped until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        advance,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] retire_cnt
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0] state;
  logic       npc_illegal;

  assign npc_illegal = (npc_in[1:0] != 2'b00) || (npc_in < PC_MIN) || (npc_in > PC_MAX);

  // Gating with reset keeps the strobe low while reset is being applied.
  assign imem_req  = (state == ST_FETCH) && reset;
  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      retire_cnt  <= 32'd0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance && !stall) begin
            // Faulting target is still loaded so debug can read it back from pc.
            pc          <= npc_in;
            instr_valid <= 1'b0;
            retire_cnt  <= retire_cnt + 32'd1;
            if (npc_illegal) begin
              fetch_err <= 1'b1;
              state     <= ST_ERR;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: begin
          fetch_err   <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: handshake, stall, error trap,
// ignored stray responses, counter wrap and mid-operation reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] npc_in;
  logic        advance;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] retire_cnt;

  int n_checks;
  int n_fails;
  int req_seen;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .npc_in      (npc_in),
    .advance     (advance),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc4         (pc4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT sits in FETCH; returns at a negedge in HOLD.
  task automatic serve(input logic [31:0] data);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fails = 0;
    reset = 1'b0; advance = 1'b0; stall = 1'b0; npc_in = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_pc", pc, 32'h0000_3000);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    check_eq("rst_cnt", retire_cnt, 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);

    // first fetch
    reset = 1'b1; #1;
    check_eq("f1_req", 32'(imem_req), 32'd1);
    check_eq("f1_addr", imem_addr, 32'h0000_3000);
    serve(32'h3C01_1234);
    check_eq("f1_instr", instr, 32'h3C01_1234);
    check_eq("f1_valid", 32'(instr_valid), 32'd1);
    check_eq("f1_pc4", pc4, 32'h0000_3004);
    check_eq("f1_req_off", 32'(imem_req), 32'd0);

    // accepted advance
    advance = 1'b1; npc_in = 32'h0000_3004;
    @(negedge clk);
    advance = 1'b0;
    check_eq("adv_pc", pc, 32'h0000_3004);
    check_eq("adv_valid", 32'(instr_valid), 32'd0);
    check_eq("adv_cnt", retire_cnt, 32'd1);
    check_eq("adv_req", 32'(imem_req), 32'd1);
    check_eq("adv_addr", imem_addr, 32'h0000_3004);
    serve(32'h8C22_0000);

    // stall blocks advance
    stall = 1'b1; advance = 1'b1; npc_in = 32'h0000_3008; req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req) req_seen++;
      check_eq("stall_pc", pc, 32'h0000_3004);
      check_eq("stall_cnt", retire_cnt, 32'd1);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
    end
    check_eq("stall_instr", instr, 32'h8C22_0000);
    check_eq("stall_req_seen", 32'(req_seen), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    check_eq("unstall_pc", pc, 32'h0000_3008);
    check_eq("unstall_cnt", retire_cnt, 32'd2);
    check_eq("unstall_req", 32'(imem_req), 32'd1);

    // slow response, advance pulsed while waiting
    @(negedge clk);
    advance = 1'b1; npc_in = 32'h0000_300C;
    @(negedge clk);
    advance = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check_eq("wait_pc", pc, 32'h0000_3008);
    check_eq("wait_valid", 32'(instr_valid), 32'd0);
    check_eq("wait_cnt", retire_cnt, 32'd2);
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_eq("slow_instr", instr, 32'hAAAA_0001);
    check_eq("slow_valid", 32'(instr_valid), 32'd1);

    // stray response in HOLD
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("stray_instr", instr, 32'hAAAA_0001);
    check_eq("stray_valid", 32'(instr_valid), 32'd1);
    check_eq("stray_req", 32'(imem_req), 32'd0);

    // counter wrap
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    advance = 1'b1; npc_in = 32'h0000_300C;
    @(negedge clk);
    advance = 1'b0;
    check_eq("wrap_cnt", retire_cnt, 32'd0);
    check_eq("wrap_pc", pc, 32'h0000_300C);

    // reset while WAIT has a response outstanding
    @(negedge clk);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("mrst_pc", pc, 32'h0000_3000);
    check_eq("mrst_valid", 32'(instr_valid), 32'd0);
    check_eq("mrst_instr", instr, 32'd0);
    check_eq("mrst_req", 32'(imem_req), 32'd0);
    reset = 1'b1; #1;
    check_eq("mrst_req2", 32'(imem_req), 32'd1);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_eq("stale_valid", 32'(instr_valid), 32'd0);
    check_eq("stale_instr", instr, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1234;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_eq("refetch_instr", instr, 32'h3C01_1234);

    // highest legal target
    advance = 1'b1; npc_in = 32'h0000_6FFC;
    @(negedge clk);
    advance = 1'b0;
    check_eq("max_pc", pc, 32'h0000_6FFC);
    check_eq("max_err", 32'(fetch_err), 32'd0);
    check_eq("max_req", 32'(imem_req), 32'd1);
    serve(32'h0000_0001);

    // out-of-range target
    advance = 1'b1; npc_in = 32'h0000_7000;
    @(negedge clk);
    check_eq("oor_pc", pc, 32'h0000_7000);
    check_eq("oor_err", 32'(fetch_err), 32'd1);
    check_eq("oor_cnt", retire_cnt, 32'd2);
    check_eq("oor_valid", 32'(instr_valid), 32'd0);
    npc_in = 32'h0000_3000; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    advance = 1'b0; imem_rvalid = 1'b0;
    check_eq("oor_req_seen", 32'(req_seen), 32'd0);
    check_eq("oor_pc_hold", pc, 32'h0000_7000);
    check_eq("oor_err_hold", 32'(fetch_err), 32'd1);
    check_eq("oor_cnt_hold", retire_cnt, 32'd2);
    check_eq("oor_instr_hold", instr, 32'h0000_0001);

    // reset clears the trap, then a misaligned target
    reset = 1'b0;
    @(negedge clk);
    check_eq("clr_err", 32'(fetch_err), 32'd0);
    reset = 1'b1;
    serve(32'h0000_0002);
    advance = 1'b1; npc_in = 32'h0000_3002;
    @(negedge clk);
    check_eq("mis_pc", pc, 32'h0000_3002);
    check_eq("mis_err", 32'(fetch_err), 32'd1);
    check_eq("mis_cnt", retire_cnt, 32'd1);
    imem_rvalid = 1'b1; req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    advance = 1'b0; imem_rvalid = 1'b0;
    check_eq("mis_req_seen", 32'(req_seen), 32'd0);
    check_eq("mis_err_hold", 32'(fetch_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
